// File: rtl/icache.sv
// Direct-mapped instruction cache: one instruction per entry, single-cycle hit
// path and at most one outstanding instruction read to mem_controller.
module icache #(
  parameter int INDEX_WIDTH = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_flush_in,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_pc_in,
  output logic        fetch_ready_out,
  output logic        instr_ready_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_is_compressed_out,
  output logic        mem_ic_valid,
  output logic [31:0] mem_ic_aout,
  input  logic        mem_iout_ready,
  input  logic [31:0] mem_out
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;
  localparam int TAG_W   = 31 - INDEX_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  function automatic logic is_compressed(input logic [31:0] word);
    return (word[1:0] != 2'b11);
  endfunction

  state_t             r_state;
  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag  [ENTRIES];
  logic [31:0]        r_data [ENTRIES];
  logic [31:0]        r_miss_pc;
  logic               r_instr_ready;
  logic [31:0]        r_instr;
  logic [31:0]        r_instr_pc;
  logic               r_instr_comp;

  logic [31:0]            w_pc;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [INDEX_WIDTH-1:0] w_miss_idx;
  logic [TAG_W-1:0]       w_miss_tag;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_fill;

  assign w_pc       = fetch_pc_in & 32'hFFFF_FFFE;
  assign w_idx      = w_pc[INDEX_WIDTH:1];
  assign w_tag      = w_pc[31:INDEX_WIDTH+1];
  assign w_miss_idx = r_miss_pc[INDEX_WIDTH:1];
  assign w_miss_tag = r_miss_pc[31:INDEX_WIDTH+1];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign fetch_ready_out = (r_state == ST_IDLE);
  assign w_accept        = fetch_valid_in && fetch_ready_out && rdy_in && !need_flush_in;
  // A flush or reset in the response cycle discards the returning word.
  assign w_fill          = (r_state == ST_MISS) && mem_iout_ready && rdy_in
                           && !need_flush_in && !rst_in;
  assign mem_ic_valid    = (r_state == ST_MISS) && !mem_iout_ready;
  assign mem_ic_aout     = r_miss_pc;

  assign instr_ready_out         = r_instr_ready;
  assign instr_out               = r_instr;
  assign instr_pc_out            = r_instr_pc;
  assign instr_is_compressed_out = r_instr_comp;

  // Tag/data arrays are written only by a completed, non-flushed fill.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_miss_idx]  <= w_miss_tag;
      r_data[w_miss_idx] <= mem_out;
    end
  end

  // Control FSM, valid bits and registered result outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= ST_IDLE;
      r_valid       <= '0;
      r_miss_pc     <= 32'h0000_0000;
      r_instr_ready <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_instr_comp  <= 1'b0;
    end else if (rdy_in) begin
      if (need_flush_in) begin
        r_state       <= ST_IDLE;
        r_instr_ready <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept && w_hit) begin
              r_instr_ready <= 1'b1;
              r_instr       <= r_data[w_idx];
              r_instr_pc    <= w_pc;
              r_instr_comp  <= is_compressed(r_data[w_idx]);
            end else if (w_accept) begin
              r_miss_pc     <= w_pc;
              r_state       <= ST_MISS;
              r_instr_ready <= 1'b0;
            end else begin
              r_instr_ready <= 1'b0;
            end
          end
          ST_MISS: begin
            if (mem_iout_ready) begin
              r_valid[w_miss_idx] <= 1'b1;
              r_instr_ready       <= 1'b1;
              r_instr             <= mem_out;
              r_instr_pc          <= r_miss_pc;
              r_instr_comp        <= is_compressed(mem_out);
              r_state             <= ST_IDLE;
            end else begin
              r_instr_ready <= 1'b0;
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_instr_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: a mem_controller model plus a line-level reference cache;
// table vectors, hand-written corner sequences and a randomized fetch stream.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        fetch_valid_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_ready_out;
  logic        instr_ready_out;
  logic [31:0] instr_out;
  logic [31:0] instr_pc_out;
  logic        instr_is_compressed_out;
  logic        mem_ic_valid;
  logic [31:0] mem_ic_aout;
  logic        mem_iout_ready;
  logic [31:0] mem_out;

  always #5 clk_in = ~clk_in;

  icache #(.INDEX_WIDTH(6)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .fetch_valid_in(fetch_valid_in), .fetch_pc_in(fetch_pc_in),
    .fetch_ready_out(fetch_ready_out), .instr_ready_out(instr_ready_out),
    .instr_out(instr_out), .instr_pc_out(instr_pc_out),
    .instr_is_compressed_out(instr_is_compressed_out),
    .mem_ic_valid(mem_ic_valid), .mem_ic_aout(mem_ic_aout),
    .mem_iout_ready(mem_iout_ready), .mem_out(mem_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // mem_controller model state
  bit          m_busy = 1'b0;
  int          m_cnt = 0, m_lat = 0, m_stall = 0, m_reqs = 0;
  logic [31:0] m_last_addr = 32'h0, m_word = 32'h0;

  // reference cache: which PC each of the 64 lines holds
  bit          ref_v  [64];
  logic [31:0] ref_pc [64];

  typedef struct {
    logic [31:0] pc;
    bit          hit;
    logic [31:0] data;
    bit          comp;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] h;
    if (pc == 32'h0000_0000) return 32'h0010_0093;
    if (pc == 32'h0000_0002) return 32'h0000_4501;
    h = (pc ^ 32'h5BD1_E995) * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    if (h[20]) return {16'h0000, h[15:2], 2'b01};
    return {h[31:2], 2'b11};
  endfunction

  function automatic int lat_of(input logic [31:0] w);
    return (w[1:0] == 2'b11) ? 5 : 3;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 1) % 64);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Model of mem_controller's instruction port: 5 cycles for a 32-bit word,
  // 3 for a compressed one, plus an optional arbitration stall.
  initial begin
    mem_iout_ready = 1'b0;
    mem_out        = 32'h0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        mem_iout_ready = 1'b0;
        m_busy         = 1'b0;
      end else if (!rdy_in) begin
        m_busy = m_busy;
      end else if (mem_iout_ready) begin
        mem_iout_ready = 1'b0;
        mem_out        = $urandom;
        m_busy         = 1'b0;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == m_lat) begin
          mem_iout_ready = 1'b1;
          mem_out        = m_word;
        end
      end else if (mem_ic_valid) begin
        m_busy      = 1'b1;
        m_cnt       = 0;
        m_last_addr = mem_ic_aout;
        m_word      = mem_word(mem_ic_aout);
        m_lat       = lat_of(m_word) + m_stall;
        m_reqs++;
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input bit exp_hit,
                          input logic [31:0] exp_data, input bit exp_comp);
    int req0, k, exp_lat;
    bit seen;
    exp_lat = exp_hit ? 1 : (lat_of(exp_data) + m_stall + 2);
    check("fetch_ready_before", {31'd0, fetch_ready_out}, 32'd1);
    req0 = m_reqs;
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    step();
    fetch_valid_in = 1'b0;
    fetch_pc_in    = $urandom;
    seen = 1'b0;
    k    = 1;
    while (!seen && k <= 200) begin
      if (instr_ready_out) seen = 1'b1;
      else begin
        step();
        k++;
      end
    end
    check("pulse_seen", {31'd0, seen}, 32'd1);
    check("latency", k, exp_lat);
    check("instr_out", instr_out, exp_data);
    check("instr_pc_out", instr_pc_out, pc);
    check("compressed", {31'd0, instr_is_compressed_out}, {31'd0, exp_comp});
    check("mem_requests", m_reqs - req0, exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) check("miss_addr", m_last_addr, pc);
    step();
    check("pulse_single", {31'd0, instr_ready_out}, 32'd0);
    ref_v[line_of(pc)]  = 1'b1;
    ref_pc[line_of(pc)] = pc;
  endtask

  initial begin
    logic [31:0] pc, w;
    int k, hi, bad, pulses, req0;
    bit hit;

    rst_in = 1'b1; rdy_in = 1'b1; need_flush_in = 1'b0;
    fetch_valid_in = 1'b0; fetch_pc_in = 32'h0;
    for (int i = 0; i < 64; i++) begin ref_v[i] = 1'b0; ref_pc[i] = 32'h0; end

    tbl[0] = '{32'h0000_0000, 1'b0, 32'h0010_0093, 1'b0};
    tbl[1] = '{32'h0000_0000, 1'b1, 32'h0010_0093, 1'b0};
    tbl[2] = '{32'h0000_0002, 1'b0, 32'h0000_4501, 1'b1};
    tbl[3] = '{32'h0000_0082, 1'b0, mem_word(32'h82), 1'b0};
    tbl[4] = '{32'h0000_0002, 1'b0, 32'h0000_4501, 1'b1};
    tbl[5] = '{32'h0000_0082, 1'b0, mem_word(32'h82), 1'b0};
    tbl[6] = '{32'h0000_0004, 1'b0, mem_word(32'h4), 1'b0};
    tbl[7] = '{32'h0000_0008, 1'b0, mem_word(32'h8), 1'b0};
    tbl[8] = '{32'h0000_000C, 1'b0, mem_word(32'hC), 1'b0};
    tbl[9] = '{32'h0000_0004, 1'b1, mem_word(32'h4), 1'b0};
    for (int i = 3; i < 10; i++) tbl[i].comp = (tbl[i].data[1:0] != 2'b11);

    step(); step();
    rst_in = 1'b0;
    check("rst_instr_ready", {31'd0, instr_ready_out}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc_out, 32'd0);
    check("rst_compressed", {31'd0, instr_is_compressed_out}, 32'd0);
    check("rst_ic_aout", mem_ic_aout, 32'd0);
    check("rst_ic_valid", {31'd0, mem_ic_valid}, 32'd0);
    check("rst_fetch_ready", {31'd0, fetch_ready_out}, 32'd1);

    for (int i = 0; i < 10; i++) do_fetch(tbl[i].pc, tbl[i].hit, tbl[i].data, tbl[i].comp);

    // back-to-back hits with a 3-cycle rdy_in hold in the middle
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h0; step();
    check("b2b_pulse0", {31'd0, instr_ready_out}, 32'd1);
    check("b2b_pc0", instr_pc_out, 32'h0);
    fetch_pc_in = 32'h4; step();
    check("b2b_pulse4", {31'd0, instr_ready_out}, 32'd1);
    check("b2b_pc4", instr_pc_out, 32'h4);
    rdy_in = 1'b0; fetch_pc_in = 32'h8;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_ready", {31'd0, instr_ready_out}, 32'd1);
      check("frz_pc", instr_pc_out, 32'h4);
      check("frz_data", instr_out, mem_word(32'h4));
    end
    rdy_in = 1'b1; step();
    check("b2b_pc8", instr_pc_out, 32'h8);
    check("b2b_data8", instr_out, mem_word(32'h8));
    fetch_pc_in = 32'hC; step();
    check("b2b_pulseC", {31'd0, instr_ready_out}, 32'd1);
    check("b2b_pcC", instr_pc_out, 32'hC);
    fetch_valid_in = 1'b0; step();
    check("b2b_end", {31'd0, instr_ready_out}, 32'd0);
    check("b2b_no_mem", {31'd0, mem_ic_valid}, 32'd0);

    // arbitration stall of 20 extra cycles
    m_stall = 20; pc = 32'h200; w = mem_word(pc); req0 = m_reqs;
    fetch_valid_in = 1'b1; fetch_pc_in = pc; step(); fetch_valid_in = 1'b0;
    hi = 0; bad = 0; k = 0;
    while (!mem_iout_ready && k < 60) begin
      @(negedge clk_in); #1; k++;
      if (!mem_iout_ready) begin
        hi++;
        if (!mem_ic_valid || fetch_ready_out) bad++;
      end
    end
    check("stall_hold", bad, 32'd0);
    check("stall_cycles", hi, lat_of(w) + 20);
    check("stall_ic_valid_drop", {31'd0, mem_ic_valid}, 32'd0);
    @(posedge clk_in); #1;
    check("stall_pulse", {31'd0, instr_ready_out}, 32'd1);
    check("stall_data", instr_out, w);
    check("stall_one_req", m_reqs - req0, 32'd1);
    m_stall = 0; step();
    ref_v[line_of(pc)] = 1'b1; ref_pc[line_of(pc)] = pc;

    // flush two cycles into a miss
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h100; step(); fetch_valid_in = 1'b0;
    check("flush_in_miss", {31'd0, fetch_ready_out}, 32'd0);
    step();
    need_flush_in = 1'b1; step(); need_flush_in = 1'b0;
    check("flush_ready", {31'd0, instr_ready_out}, 32'd0);
    check("flush_idle", {31'd0, fetch_ready_out}, 32'd1);
    pulses = 0; k = 0;
    while ((m_busy || mem_iout_ready) && k < 40) begin
      step(); k++;
      if (instr_ready_out) pulses++;
    end
    check("flush_no_pulse", pulses, 32'd0);
    check("flush_mem_drained", {31'd0, m_busy}, 32'd0);
    do_fetch(32'h100, 1'b0, mem_word(32'h100), mem_word(32'h100) != 32'h3 && mem_word(32'h100) ? (mem_word(32'h100) & 32'h3) != 32'h3 : 1'b0);

    // flush in the same cycle as iout_ready
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h180; step(); fetch_valid_in = 1'b0;
    k = 0;
    while (!mem_iout_ready && k < 40) begin @(negedge clk_in); #1; k++; end
    check("flushc_ready_seen", {31'd0, mem_iout_ready}, 32'd1);
    need_flush_in = 1'b1; @(posedge clk_in); #1; need_flush_in = 1'b0;
    check("flushc_no_pulse", {31'd0, instr_ready_out}, 32'd0);
    check("flushc_idle", {31'd0, fetch_ready_out}, 32'd1);
    step();
    w = mem_word(32'h180);
    do_fetch(32'h180, 1'b0, w, w[1:0] != 2'b11);

    // reset in the middle of a miss
    fetch_valid_in = 1'b1; fetch_pc_in = 32'h300; step(); fetch_valid_in = 1'b0;
    step();
    rst_in = 1'b1; step(); rst_in = 1'b0;
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
    check("rstm_idle", {31'd0, fetch_ready_out}, 32'd1);
    check("rstm_ic_valid", {31'd0, mem_ic_valid}, 32'd0);
    check("rstm_aout", mem_ic_aout, 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin step(); if (instr_ready_out) pulses++; end
    check("rstm_no_pulse", pulses, 32'd0);
    do_fetch(32'h0, 1'b0, 32'h0010_0093, 1'b0);

    // randomized fetch stream against the reference cache
    for (int i = 0; i < 150; i++) begin
      pc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 63) << 1);
      hit = ref_v[line_of(pc)] && (ref_pc[line_of(pc)] == pc);
      m_stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      w = mem_word(pc);
      do_fetch(pc, hit, w, w[1:0] != 2'b11);
      repeat ($urandom_range(0, 2)) step();
    end
    m_stall = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
